// File: rtl/vmicro16_mmu_pkg.sv
// vmicro16_mmu_pkg: MMIO offsets, region codes and FSM states shared by the MMU slice.
package vmicro16_mmu_pkg;

    // Request sequencing: one access in flight, fixed three-state walk.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mmu_state_e;

    // Target of the latched request address.
    typedef enum logic [1:0] {
        REGION_SCRATCH = 2'd0,
        REGION_MMIO    = 2'd1,
        REGION_NONE    = 2'd2
    } mmu_region_e;

    // Word offsets inside the MMIO window.
    localparam logic [1:0] VMICRO16_MMIO_GPIO_OUT = 2'd0;
    localparam logic [1:0] VMICRO16_MMIO_GPIO_IN  = 2'd1;
    localparam logic [1:0] VMICRO16_MMIO_TIMER    = 2'd2;

    // An access outside the map, or a store to a read-only MMIO register, is a fault.
    function automatic logic is_fault(input mmu_region_e region, input logic we,
                                      input logic [1:0] offset);
        return (region == REGION_NONE) ||
               ((region == REGION_MMIO) && we && (offset != VMICRO16_MMIO_GPIO_OUT));
    endfunction

endpackage

// File: rtl/vmicro16_bram.sv
// vmicro16_bram: single-port scratch RAM with registered, enable-gated read port.
// Contents are never reset.
module vmicro16_bram #(
    parameter int MEM_WIDTH      = 16,
    parameter int MEM_DEPTH      = 64,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      mem_en,
    input  logic                      mem_we,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]      mem_in,
    output logic [MEM_WIDTH-1:0]      mem_out
);

    logic [MEM_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];
    logic [MEM_WIDTH-1:0] mem_out_r;

    // Write port and registered read (read-before-write on the same word).
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_r[mem_addr] <= mem_in;
            end
            mem_out_r <= mem_r[mem_addr];
        end
    end

    assign mem_out = mem_out_r;

endmodule

// File: rtl/vmicro16_mmu_periph.sv
// vmicro16_mmu_periph: GPIO_OUT register, GPIO_IN sampling, free-running timer and
// the MMIO read mux. Read data is captured on the ACCESS edge and held for RESP.
module vmicro16_mmu_periph
    import vmicro16_mmu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  access,
    input  logic                  sel,
    input  logic                  we,
    input  logic [1:0]            offset,
    input  logic [GPIO_WIDTH-1:0] wdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [GPIO_WIDTH-1:0] gpio_out_r;
    logic [DATA_WIDTH-1:0] timer_r;
    logic [DATA_WIDTH-1:0] rd_mux_s;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  gpio_wr_s;

    assign gpio_wr_s = access & sel & we & (offset == VMICRO16_MMIO_GPIO_OUT);

    // GPIO_OUT register: only a store to offset 0 changes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_r <= {GPIO_WIDTH{1'b0}};
        end else if (gpio_wr_s) begin
            gpio_out_r <= wdata;
        end else begin
            gpio_out_r <= gpio_out_r;
        end
    end

    // Free-running timer, wraps naturally at full width.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= {DATA_WIDTH{1'b0}};
        end else begin
            timer_r <= timer_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // MMIO read mux; GPIO values zero-extend to the data width.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        case (offset)
            VMICRO16_MMIO_GPIO_OUT: rd_mux_s = DATA_WIDTH'(gpio_out_r);
            VMICRO16_MMIO_GPIO_IN:  rd_mux_s = DATA_WIDTH'(gpio_in);
            VMICRO16_MMIO_TIMER:    rd_mux_s = timer_r;
            default:                rd_mux_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Capture read data on the ACCESS edge; non-MMIO accesses and stores return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (access) begin
            rdata_r <= (sel && !we) ? rd_mux_s : {DATA_WIDTH{1'b0}};
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign gpio_out = gpio_out_r;
    assign rdata    = rdata_r;

endmodule

// File: rtl/vmicro16_mmu.sv
// vmicro16_mmu: ME-stage memory responder. One request at a time walks
// IDLE -> ACCESS -> RESP; ack pulses in RESP for every region.
// Optional feature macro: VMICRO16_MMU_ERR_EN (report faults on err).
module vmicro16_mmu
    import vmicro16_mmu_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    SCRATCH_DEPTH = 64,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE     = 16'h8000,
    parameter int                    GPIO_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out
);

    localparam int                    SCRATCH_AW    = $clog2(SCRATCH_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SCRATCH_LIMIT = ADDR_WIDTH'(SCRATCH_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MMIO_LAST     = MMIO_BASE + ADDR_WIDTH'(2);

    mmu_state_e            state_r, state_next_s;
    mmu_region_e           region_s, region_r;
    logic [1:0]            mmio_off_s, mmio_off_r;
    logic                  we_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [SCRATCH_AW-1:0] scr_addr_r;
    logic                  ack_s, busy_s, in_access_s, bram_we_s;
    logic [DATA_WIDTH-1:0] bram_dout_s, periph_rdata_s;

    // Offset inside the MMIO window; only meaningful when the region is MMIO.
    assign mmio_off_s = req_addr[1:0] - MMIO_BASE[1:0];

    // Region decode of the incoming address.
    always_comb begin
        region_s = REGION_NONE;
        if (req_addr < SCRATCH_LIMIT) begin
            region_s = REGION_SCRATCH;
        end else if ((req_addr >= MMIO_BASE) && (req_addr <= MMIO_LAST)) begin
            region_s = REGION_MMIO;
        end else begin
            region_s = REGION_NONE;
        end
    end

    // Latch the request when it is accepted in IDLE; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            region_r   <= REGION_NONE;
            mmio_off_r <= 2'd0;
            we_r       <= 1'b0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            scr_addr_r <= {SCRATCH_AW{1'b0}};
        end else if ((state_r == ST_IDLE) && req) begin
            region_r   <= region_s;
            mmio_off_r <= mmio_off_s;
            we_r       <= req_we;
            wdata_r    <= req_wdata;
            scr_addr_r <= req_addr[SCRATCH_AW-1:0];
        end else begin
            region_r   <= region_r;
            mmio_off_r <= mmio_off_r;
            we_r       <= we_r;
            wdata_r    <= wdata_r;
            scr_addr_r <= scr_addr_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; req is only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        ack_s       = 1'b0;
        busy_s      = 1'b0;
        in_access_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ack_s       = 1'b0;
                busy_s      = 1'b0;
                in_access_s = 1'b0;
            end
            ST_ACCESS: begin
                busy_s      = 1'b1;
                in_access_s = 1'b1;
            end
            ST_RESP: begin
                ack_s  = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                ack_s       = 1'b0;
                busy_s      = 1'b0;
                in_access_s = 1'b0;
            end
        endcase
    end

    // A reset on the ACCESS edge must not let a scratch store commit.
    assign bram_we_s = in_access_s & we_r & (region_r == REGION_SCRATCH) & ~reset;

    vmicro16_bram #(
        .MEM_WIDTH (DATA_WIDTH),
        .MEM_DEPTH (SCRATCH_DEPTH)
    ) u_scratch (
        .clk      (clk),
        .mem_en   (in_access_s),
        .mem_we   (bram_we_s),
        .mem_addr (scr_addr_r),
        .mem_in   (wdata_r),
        .mem_out  (bram_dout_s)
    );

    vmicro16_mmu_periph #(
        .DATA_WIDTH (DATA_WIDTH),
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_periph (
        .clk      (clk),
        .reset    (reset),
        .access   (in_access_s),
        .sel      (region_r == REGION_MMIO),
        .we       (we_r),
        .offset   (mmio_off_r),
        .wdata    (wdata_r[GPIO_WIDTH-1:0]),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .rdata    (periph_rdata_s)
    );

`ifdef VMICRO16_MMU_ERR_EN
    logic err_r;

    // Fault flag captured on the ACCESS edge, presented with ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (in_access_s) begin
            err_r <= is_fault(region_r, we_r, mmio_off_r);
        end else begin
            err_r <= err_r;
        end
    end

    assign err = ack_s & err_r;
`else
    assign err = 1'b0;
`endif

    // Read data only while acking; the periph path already returns zero for non-MMIO.
    assign rdata = !ack_s ? {DATA_WIDTH{1'b0}} :
                   ((region_r == REGION_SCRATCH) && !we_r) ? bram_dout_s : periph_rdata_s;

    assign ack  = ack_s;
    assign busy = busy_s;

endmodule

// File: tb/tb_vmicro16_mmu.sv
// tb_vmicro16_mmu: directed vector table, reset/timer sequences and randomized
// traffic checked against an address-map reference model.
module tb_vmicro16_mmu;

`ifdef VMICRO16_MMU_ERR_EN
    localparam logic ERRV = 1'b1;
`else
    localparam logic ERRV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        ack, err, busy;
    logic [15:0] rdata;
    logic [7:0]  gpio_in, gpio_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [15:0] m_scratch [0:63];
    logic [7:0]  m_gpio = 8'h00;
    logic [15:0] m_timer;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  gpin;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs [0:17];

    always #5 clk = ~clk;

    // Timer model: cycles elapsed since reset was last seen.
    always @(posedge clk) m_timer <= reset ? 16'h0000 : m_timer + 16'h0001;

    vmicro16_mmu dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request starting at a negedge in IDLE; returns at the next IDLE negedge.
    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [7:0] gpin, output logic [15:0] rd, output logic er,
                          output logic [7:0] gp, output logic [15:0] tcap);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; gpio_in = gpin;
        @(negedge clk);
        check("ack_in_access", {15'd0, ack}, 16'h0000);
        check("busy_in_access", {15'd0, busy}, 16'h0001);
        tcap = m_timer;
        @(negedge clk);
        check("ack_in_resp", {15'd0, ack}, 16'h0001);
        check("busy_in_resp", {15'd0, busy}, 16'h0001);
        rd = rdata; er = err; gp = gpio_out;
        // Scramble the held inputs and keep req high across the RESP edge.
        req_we = ~we; req_addr = 16'($urandom); req_wdata = 16'($urandom);
        @(negedge clk);
        check("ack_after_resp", {15'd0, ack}, 16'h0000);
        check("busy_after_resp", {15'd0, busy}, 16'h0000);
        req = 1'b0;
    endtask

    // Reference model of one access from the address-map rules.
    task automatic model_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [7:0] gpin, input logic [15:0] tcap,
                             output logic [15:0] e_rd, output logic e_err);
        logic fault;
        fault = 1'b0;
        e_rd  = 16'h0000;
        if (int'(addr) < 64) begin
            if (we) m_scratch[addr[5:0]] = wdata;
            else    e_rd = m_scratch[addr[5:0]];
        end else if (addr == 16'h8000) begin
            if (we) m_gpio = wdata[7:0];
            else    e_rd = {8'h00, m_gpio};
        end else if (addr == 16'h8001) begin
            if (we) fault = 1'b1;
            else    e_rd = {8'h00, gpin};
        end else if (addr == 16'h8002) begin
            if (we) fault = 1'b1;
            else    e_rd = tcap;
        end else begin
            fault = 1'b1;
        end
        e_err = fault & ERRV;
    endtask

    task automatic run_model(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [7:0] gpin, input string tag);
        logic [15:0] rd, tcap, e_rd;
        logic er, e_err;
        logic [7:0] gp;
        do_txn(we, addr, wdata, gpin, rd, er, gp, tcap);
        model_txn(we, addr, wdata, gpin, tcap, e_rd, e_err);
        check($sformatf("%s_rdata@%h", tag, addr), rd, e_rd);
        check($sformatf("%s_err@%h", tag, addr), {15'd0, er}, {15'd0, e_err});
        check($sformatf("%s_gpio@%h", tag, addr), {8'd0, gp}, {8'd0, m_gpio});
    endtask

    initial begin
        logic [15:0] rd, tcap, e_rd, t1, t2;
        logic er, e_err;
        logic [7:0] gp;

        vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 8'h00, 16'h0000, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 8'h00, 16'hBEEF, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 16'h8000, 16'h12A5, 8'h00, 16'h0000, 1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 16'h8000, 16'h0000, 8'h00, 16'h00A5, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 16'h8001, 16'h0000, 8'h3C, 16'h003C, 1'b0, 8'hA5};
        vecs[5]  = '{1'b1, 16'h8001, 16'hFFFF, 8'h3C, 16'h0000, ERRV, 8'hA5};
        vecs[6]  = '{1'b0, 16'h8000, 16'h0000, 8'h3C, 16'h00A5, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 16'h8001, 16'h0000, 8'h3C, 16'h003C, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 16'h4000, 16'h0000, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[9]  = '{1'b1, 16'h4000, 16'h1111, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[10] = '{1'b1, 16'h8002, 16'hAAAA, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[11] = '{1'b1, 16'h003F, 16'h7E7E, 8'h00, 16'h0000, 1'b0, 8'hA5};
        vecs[12] = '{1'b0, 16'h003F, 16'h0000, 8'h00, 16'h7E7E, 1'b0, 8'hA5};
        vecs[13] = '{1'b0, 16'h0040, 16'h0000, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[14] = '{1'b0, 16'h8003, 16'h0000, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[15] = '{1'b0, 16'h7FFF, 16'h0000, 8'h00, 16'h0000, ERRV, 8'hA5};
        vecs[16] = '{1'b1, 16'h0007, 16'h1234, 8'h00, 16'h0000, 1'b0, 8'hA5};
        vecs[17] = '{1'b0, 16'h8001, 16'h0000, 8'hC3, 16'h00C3, 1'b0, 8'hA5};

        reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 16'h0000;
        req_wdata = 16'h0000; gpio_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ack", {15'd0, ack}, 16'h0000);
        check("reset_err", {15'd0, err}, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_gpio_out", {8'd0, gpio_out}, 16'h0000);

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gpin, rd, er, gp, tcap);
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gpin, tcap, e_rd, e_err);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {15'd0, er}, {15'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_gpio", i), {8'd0, gp}, {8'd0, vecs[i].exp_gpio});
        end

        // Reset during ACCESS of a store: no ack, back to IDLE, store dropped.
        req = 1'b1; req_we = 1'b1; req_addr = 16'h0007; req_wdata = 16'h5555;
        @(negedge clk);
        check("rst_mid_busy_access", {15'd0, busy}, 16'h0001);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_gpio = 8'h00;
        check("rst_mid_ack", {15'd0, ack}, 16'h0000);
        check("rst_mid_busy", {15'd0, busy}, 16'h0000);
        check("rst_mid_gpio", {8'd0, gpio_out}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_ack", {15'd0, ack}, 16'h0000);
        end
        do_txn(1'b0, 16'h0007, 16'h0000, 8'h00, rd, er, gp, tcap);
        check("rst_mid_prior_value", rd, 16'h1234);

        // Timer reads with requests sampled 10 cycles apart.
        run_model(1'b0, 16'h8002, 16'h0000, 8'h00, "timer_a");
        do_txn(1'b0, 16'h8002, 16'h0000, 8'h00, t1, er, gp, tcap);
        check("timer_first", t1, tcap);
        repeat (7) @(negedge clk);
        do_txn(1'b0, 16'h8002, 16'h0000, 8'h00, t2, er, gp, tcap);
        check("timer_delta10", t2 - t1, 16'd10);

        // Fill scratch, then randomized traffic against the model.
        for (int i = 0; i < 64; i++)
            run_model(1'b1, 16'(i), 16'($urandom), 8'($urandom), "fill");
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            int cat;
            cat = int'($urandom_range(0, 3));
            case (cat)
                0, 1:    a = 16'($urandom_range(0, 63));
                2:       a = 16'h8000 + 16'($urandom_range(0, 2));
                default: begin
                    a = 16'h0000;
                    for (int k = 0; k < 50 && (int'(a) < 64 || (a >= 16'h8000 && a <= 16'h8002)); k++)
                        a = 16'($urandom);
                    if (int'(a) < 64 || (a >= 16'h8000 && a <= 16'h8002)) a = 16'h1234;
                end
            endcase
            run_model(1'($urandom_range(0, 1)), a, 16'($urandom), 8'($urandom), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Timer wrap: capture 0xFFFF, then the next read lands just past zero.
        for (int i = 0; i < 70000 && m_timer !== 16'hFFFE; i++) @(negedge clk);
        check("timer_wait_bound", m_timer, 16'hFFFE);
        do_txn(1'b0, 16'h8002, 16'h0000, 8'h00, t1, er, gp, tcap);
        check("timer_ffff", t1, 16'hFFFF);
        do_txn(1'b0, 16'h8002, 16'h0000, 8'h00, t2, er, gp, tcap);
        check("timer_wrapped", t2, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
